// File: rtl/wb_accel_pkg.sv
// Shared register map, field positions, ID constant and sequencer state encoding.
// No logic of its own; imported by the register block and the sequencer.
// Byte-merge helper applies Wishbone byte selects to RW register writes.
package wb_accel_pkg;

    localparam logic [3:0] OFF_CTRL    = 4'd0;
    localparam logic [3:0] OFF_STATUS  = 4'd1;
    localparam logic [3:0] OFF_CLA_OPS = 4'd2;
    localparam logic [3:0] OFF_CLA_CIN = 4'd3;
    localparam logic [3:0] OFF_MUL_OPS = 4'd4;
    localparam logic [3:0] OFF_CLA_RES = 4'd5;
    localparam logic [3:0] OFF_MUL_RES = 4'd6;
    localparam logic [3:0] OFF_ID      = 4'd7;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int CLA_COUT_BIT    = 16;

    localparam logic [31:0] ACCEL_ID = 32'hACC0_0001;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_RUN     = 2'd1,
        SEQ_CAPTURE = 2'd2
    } seq_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_accel_seq.sv
// Run sequencer: IDLE -> RUN for LAT cycles -> one CAPTURE cycle -> IDLE.
// Latency: busy rises the cycle after start, capture pulses LAT cycles later.
// Backpressure: none; a start while busy is dropped without reloading the counter.
module wb_accel_seq
    import wb_accel_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic start,
    output logic busy,
    output logic capture,
    output logic done_set
);

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    seq_state_e state_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       capture_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= SEQ_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            capture_q <= 1'b0;
        end else begin
            case (state_q)
                SEQ_RUN: begin
                    if (cnt_q <= 4'd1) begin
                        state_q   <= SEQ_CAPTURE;
                        cnt_q     <= 4'd0;
                        busy_q    <= 1'b0;
                        capture_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                // CAPTURE is not busy, so a start landing here begins a fresh run.
                default: begin
                    capture_q <= 1'b0;
                    if (start) begin
                        state_q <= SEQ_RUN;
                        cnt_q   <= LAT_CNT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= SEQ_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign capture  = capture_q;
    assign done_set = capture_q;

endmodule

// File: rtl/wb_accel_regs.sv
// Wishbone register block for the CLA/multiplier accelerator; WB_ACCEL_IRQ_EN enables irq_o.
// Latency: every access acked one cycle after the strobe, read data registered with the ack.
// Backpressure: never stalls; back-to-back strobes are acked every other cycle.
module wb_accel_regs
    import wb_accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          LAT       = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] opa_o,
    output logic [15:0] opb_o,
    output logic        cin_o,
    output logic [7:0]  mx_o,
    output logic [7:0]  my_o,
    input  logic [15:0] sum_i,
    input  logic        cout_i,
    input  logic [15:0] product_i,
    output logic        irq_o
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] opa_q, opa_d, opb_q, opb_d;
    logic        cin_q, cin_d;
    logic [7:0]  mx_q, mx_d, my_q, my_d;
    logic        done_q, done_d;
    logic [15:0] sum_q, sum_d, prod_q, prod_d;
    logic        cout_q, cout_d;
    logic        irq_en_q;

    logic        in_win, reg_wr, ctrl_wr, status_wr, start;
    logic        busy, capture, done_set;
    logic [3:0]  reg_off;
    logic [31:0] cla_merged, rdata;
    logic        unused_adr_lsbs;

    assign unused_adr_lsbs = ^wbs_adr_i[1:0];

    assign ack_d     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign in_win    = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
    assign reg_off   = wbs_adr_i[5:2];
    assign reg_wr    = ack_d & wbs_we_i & in_win;
    assign ctrl_wr   = reg_wr & (reg_off == OFF_CTRL) & wbs_sel_i[0];
    assign status_wr = reg_wr & (reg_off == OFF_STATUS) & wbs_sel_i[0];
    assign start     = ctrl_wr & wbs_dat_i[CTRL_START_BIT];

    assign cla_merged = merge_bytes({opb_q, opa_q}, wbs_dat_i, wbs_sel_i);

    wb_accel_seq #(
        .LAT(LAT)
    ) u_seq (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .start    (start),
        .busy     (busy),
        .capture  (capture),
        .done_set (done_set)
    );

    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        cin_d  = cin_q;
        mx_d   = mx_q;
        my_d   = my_q;
        done_d = done_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        prod_d = prod_q;
        // Operands are frozen for the whole run.
        if (reg_wr && !busy) begin
            case (reg_off)
                OFF_CLA_OPS: {opb_d, opa_d} = cla_merged;
                OFF_CLA_CIN: if (wbs_sel_i[0]) cin_d = wbs_dat_i[0];
                OFF_MUL_OPS: begin
                    if (wbs_sel_i[0]) mx_d = wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) my_d = wbs_dat_i[15:8];
                end
                default: ;
            endcase
        end
        if (status_wr && wbs_dat_i[STATUS_DONE_BIT]) done_d = 1'b0;
        if (done_set) done_d = 1'b1;
        if (capture) begin
            sum_d  = sum_i;
            cout_d = cout_i;
            prod_d = product_i;
        end
    end

    always_comb begin
        rdata = '0;
        if (in_win) begin
            case (reg_off)
                OFF_CTRL:    rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
                OFF_STATUS: begin
                    rdata[STATUS_BUSY_BIT] = busy;
                    rdata[STATUS_DONE_BIT] = done_q;
                end
                OFF_CLA_OPS: rdata = {opb_q, opa_q};
                OFF_CLA_CIN: rdata[0] = cin_q;
                OFF_MUL_OPS: rdata[15:0] = {my_q, mx_q};
                OFF_CLA_RES: begin
                    rdata[15:0]         = sum_q;
                    rdata[CLA_COUT_BIT] = cout_q;
                end
                OFF_MUL_RES: rdata[15:0] = prod_q;
                OFF_ID:      rdata = ACCEL_ID;
                default:     rdata = '0;
            endcase
        end
        dat_d = ack_d ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            cin_q  <= 1'b0;
            mx_q   <= '0;
            my_q   <= '0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            prod_q <= '0;
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            cin_q  <= cin_d;
            mx_q   <= mx_d;
            my_q   <= my_d;
            done_q <= done_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            prod_q <= prod_d;
        end
    end

`ifdef WB_ACCEL_IRQ_EN
    logic irq_en_d, irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
        irq_d = done_q & irq_en_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_en_q = 1'b0;
    assign irq_o    = 1'b0;
`endif

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign opa_o     = opa_q;
    assign opb_o     = opb_q;
    assign cin_o     = cin_q;
    assign mx_o      = mx_q;
    assign my_o      = my_q;

endmodule

// File: tb/tb_wb_accel_regs.sv
// Randomized Wishbone traffic against a register-level model, plus directed run/reset/irq cases.
module tb_wb_accel_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          LAT  = 4;
`ifdef WB_ACCEL_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic [3:0]  sel = '0;
    logic        ack, cin, cout, irq;
    logic [31:0] rdat;
    logic [15:0] opa, opb, sum, prod;
    logic [7:0]  mx, my;

    always #5 clk = ~clk;

    // Accelerator stand-in: plain arithmetic on the operand outputs.
    assign {cout, sum} = 17'(opa) + 17'(opb) + 17'(cin);
    assign prod        = 16'(mx) * 16'(my);

    wb_accel_regs #(.BASE_ADDR(BASE), .LAT(LAT)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .opa_o(opa), .opb_o(opb), .cin_o(cin), .mx_o(mx), .my_o(my),
        .sum_i(sum), .cout_i(cout), .product_i(prod),
        .irq_o(irq)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] m_opa = '0, m_opb = '0;
    logic        m_cin = 1'b0, m_irq_en = 1'b0, m_done = 1'b0, m_busy = 1'b0;
    logic [7:0]  m_mx = '0, m_my = '0;
    logic [16:0] m_cla = '0, p_cla = '0;
    logic [15:0] m_prod = '0, p_prod = '0;

    task automatic model_reset();
        m_opa = '0; m_opb = '0; m_cin = 0; m_mx = '0; m_my = '0;
        m_irq_en = 0; m_done = 0; m_busy = 0; m_cla = '0; m_prod = '0;
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a[31:6] != BASE[31:6]) return 32'd0;
        case (a[5:2])
            4'd0: return {30'd0, m_irq_en, 1'b0};
            4'd1: return {30'd0, m_done, m_busy};
            4'd2: return {m_opb, m_opa};
            4'd3: return {31'd0, m_cin};
            4'd4: return {16'd0, m_my, m_mx};
            4'd5: return {15'd0, m_cla};
            4'd6: return {16'd0, m_prod};
            4'd7: return 32'hACC0_0001;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[31:6] != BASE[31:6]) return;
        case (a[5:2])
            4'd0: if (s[0]) begin
                if (IRQ_BUILD) m_irq_en = d[1];
                if (d[0] && !m_busy) begin
                    m_busy = 1'b1;
                    p_cla  = 17'(m_opa) + 17'(m_opb) + 17'(m_cin);
                    p_prod = 16'(m_mx) * 16'(m_my);
                end
            end
            4'd1: if (s[0] && d[1]) m_done = 1'b0;
            4'd2: if (!m_busy) begin
                if (s[0]) m_opa[7:0]  = d[7:0];
                if (s[1]) m_opa[15:8] = d[15:8];
                if (s[2]) m_opb[7:0]  = d[23:16];
                if (s[3]) m_opb[15:8] = d[31:24];
            end
            4'd3: if (!m_busy && s[0]) m_cin = d[0];
            4'd4: if (!m_busy) begin
                if (s[0]) m_mx = d[7:0];
                if (s[1]) m_my = d[15:8];
            end
            default: ;
        endcase
    endtask

    // Busy-length monitor on the sequencer's busy flag
    int busy_run = 0, busy_len = 0, run_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) busy_run = 0;
        else if (dut.busy) busy_run++;
        else if (busy_run != 0) begin
            busy_len = busy_run;
            run_cnt++;
            busy_run = 0;
        end
    end

    // Called at posedge+1; returns at posedge+1 one idle cycle after the ack.
    task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] q);
        int n;
        n = 0;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 4);
        check("ack_latency", 32'(n), 32'd1);
        q = rdat;
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        model_write(a, d, s);
        bus(1'b1, a, d, s, q);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a);
        logic [31:0] q;
        bus(1'b0, a, 32'd0, 4'hF, q);
        check(tag, q, model_rd(a));
    endtask

    function automatic logic [31:0] reg_addr(input int off);
        return BASE | (32'(off) << 2);
    endfunction

    task automatic run_wait(input int runs_before);
        repeat (LAT + 4) @(posedge clk);
        #1;
        m_busy = 1'b0; m_done = 1'b1; m_cla = p_cla; m_prod = p_prod;
        check("busy_cycles", 32'(busy_len), 32'(LAT));
        check("run_count", 32'(run_cnt - runs_before), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, a, d, opa_before;
        int rb, op;

        #3;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ops", {opb, opa}, 32'd0);
        check("rst_mul", {15'd0, cin, my, mx}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) do_read("rst_read", reg_addr(i));

        // Adder run: 5 + 3 + 1
        do_write(reg_addr(2), 32'h0003_0005, 4'hF);
        do_write(reg_addr(3), 32'h1, 4'h1);
        rb = run_cnt;
        do_write(reg_addr(0), 32'h1, 4'h1);
        run_wait(rb);
        bus(1'b0, reg_addr(5), 32'd0, 4'hF, q);
        check("cla_res", q, 32'h0000_0009);
        bus(1'b0, reg_addr(1), 32'd0, 4'hF, q);
        check("status_done", q, 32'h2);
        do_read("ctrl_start_reads0", reg_addr(0));

        // Multiplier run: 0x0B * 0x0C
        do_write(reg_addr(4), 32'h0000_0C0B, 4'h3);
        rb = run_cnt;
        do_write(reg_addr(0), 32'h1, 4'h1);
        run_wait(rb);
        bus(1'b0, reg_addr(6), 32'd0, 4'hF, q);
        check("mul_res", q, 32'h0000_0084);
        do_write(reg_addr(1), 32'h2, 4'h1);
        do_read("status_cleared", reg_addr(1));

        // Restart and operand write while busy are both ignored
        opa_before = {16'd0, opa};
        rb = run_cnt;
        do_write(reg_addr(0), 32'h1, 4'h1);
        do_write(reg_addr(0), 32'h1, 4'h1);
        do_write(reg_addr(2), 32'hFFFF_FFFF, 4'hF);
        check("opa_stable", {16'd0, opa}, opa_before);
        run_wait(rb);
        do_read("ops_after_busy", reg_addr(2));
        do_read("cla_after_busy", reg_addr(5));

        // Completion and done-clear on the same edge: set wins
        do_write(reg_addr(1), 32'h2, 4'h1);
        rb = run_cnt;
        do_write(reg_addr(0), 32'h1, 4'h1);
        repeat (3) @(posedge clk);
        #1;
        do_write(reg_addr(1), 32'h2, 4'h1);
        run_wait(rb);
        bus(1'b0, reg_addr(1), 32'd0, 4'hF, q);
        check("done_set_wins", q, 32'h2);

        // Interrupt
        do_write(reg_addr(1), 32'h2, 4'h1);
        do_write(reg_addr(0), 32'h2, 4'h1);
        do_read("ctrl_irq_en", reg_addr(0));
        rb = run_cnt;
        do_write(reg_addr(0), 32'h3, 4'h1);
        run_wait(rb);
        check("irq_on_done", {31'd0, irq}, {31'd0, IRQ_BUILD});
        do_write(reg_addr(1), 32'h2, 4'h1);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Reset mid-run
        do_write(reg_addr(2), 32'h1234_5678, 4'hF);
        rb = run_cnt;
        do_write(reg_addr(0), 32'h3, 4'h1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_ops", {opb, opa}, 32'd0);
        check("arst_misc", {13'd0, irq, ack, cin, my, mx}, 32'd0);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read("arst_status", reg_addr(1));
        do_read("arst_cla", reg_addr(5));
        do_read("arst_mul", reg_addr(6));
        do_read("arst_ctrl", reg_addr(0));
        check("arst_no_run", 32'(run_cnt - rb), 32'd0);

        // Unmapped / off-window / ID
        bus(1'b0, BASE | 32'h3C, 32'd0, 4'hF, q);
        check("unmapped_3c", q, 32'd0);
        bus(1'b0, (BASE + 32'h40) | 32'h1C, 32'd0, 4'hF, q);
        check("wrong_base", q, 32'd0);
        bus(1'b0, reg_addr(7), 32'd0, 4'hF, q);
        check("id", q, 32'hACC0_0001);

        // Held strobe: ack, gap, ack
        cyc = 1; stb = 1; we = 0; adr = reg_addr(7); sel = 4'hF;
        @(posedge clk); #1;
        check("hold_ack1", {31'd0, ack}, 32'd1);
        check("hold_dat", rdat, 32'hACC0_0001);
        @(posedge clk); #1;
        check("hold_ack_gap", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        check("hold_ack2", {31'd0, ack}, 32'd1);
        cyc = 0; stb = 0;
        @(posedge clk); #1;

        // Randomized traffic
        for (int it = 0; it < 120; it++) begin
            op = $urandom_range(0, 7);
            d  = $urandom;
            case (op)
                0, 1: do_write(reg_addr($urandom_range(2, 4)), d, 4'($urandom));
                2:    do_write(reg_addr($urandom_range(0, 1)), d & 32'hFFFF_FFFE, 4'($urandom));
                3, 4: do_read("rand_read", reg_addr($urandom_range(0, 15)));
                5: begin
                    a = $urandom;
                    if (a[31:6] == BASE[31:6]) a[31] = ~a[31];
                    if (d[0]) do_write(a, $urandom, 4'hF);
                    else do_read("rand_offwin", a);
                end
                6: do_write(reg_addr($urandom_range(8, 15)), d, 4'hF);
                default: begin
                    rb = run_cnt;
                    do_write(reg_addr(0), d | 32'h1, 4'h1);
                    if ($urandom_range(0, 1) == 1)
                        do_write(reg_addr($urandom_range(0, 4)), $urandom, 4'($urandom));
                    run_wait(rb);
                    do_read("rand_cla", reg_addr(5));
                    do_read("rand_mul", reg_addr(6));
                end
            endcase
            check("rand_irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
            check("rand_opa", {opb, opa}, {m_opb, m_opa});
            check("rand_mxy", {15'd0, m_cin, m_my, m_mx}, {15'd0, cin, my, mx});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
